// File: rtl/rx_lock_ctrl.sv
// Rx loop lock controller: flush, acquisition and tracking of the carrier/Gardner loops.
// Define RX_LOCK_STATS_EN to add the loss_events and lock_time statistics outputs.
module rx_lock_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 256,
    parameter int unsigned LOCK_WINDOW  = 64,
    parameter int unsigned LOCK_THRESH  = 128,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_COUNT   = 2,
    parameter int unsigned ACQ_FB_SHIFT = 0,
    parameter int unsigned TRK_FB_SHIFT = 2,
    parameter int unsigned ACQ_GD_SHIFT = 3,
    parameter int unsigned TRK_GD_SHIFT = 5
) (
    input  logic        clk_32M768,
    input  logic        rst_32M768,
    input  logic        enable,
    input  logic        relock,
    input  logic        rx_valid,
    input  logic [15:0] feedback_tdata,
    output logic        rst_n_rx,
    output logic [3:0]  FEEDBACK_SHIFT,
    output logic [3:0]  GARDNER_SHIFT,
    output logic        locked,
    output logic [2:0]  state_dbg,
    output logic [15:0] window_peak
`ifdef RX_LOCK_STATS_EN
    ,
    output logic [15:0] loss_events,
    output logic [15:0] lock_time
`endif
);

    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [7:0]         WIN_LEN    = 8'(LOCK_WINDOW);
    localparam logic [16:0]        THRESH     = 17'(LOCK_THRESH);
    localparam logic [7:0]         LOCK_CNT   = 8'(LOCK_COUNT);
    localparam logic [7:0]         LOSS_CNT   = 8'(LOSS_COUNT);
    localparam logic [3:0]         ACQ_FB     = 4'(ACQ_FB_SHIFT);
    localparam logic [3:0]         TRK_FB     = 4'(TRK_FB_SHIFT);
    localparam logic [3:0]         ACQ_GD     = 4'(ACQ_GD_SHIFT);
    localparam logic [3:0]         TRK_GD     = 4'(TRK_GD_SHIFT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_TRACK   = 3'd3,
        S_LOST    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [7:0]           smp_cnt_q, smp_cnt_d;
    logic [15:0]          peak_q, peak_d;
    logic [7:0]           good_cnt_q, good_cnt_d;
    logic [7:0]           bad_cnt_q, bad_cnt_d;
    logic [15:0]          win_peak_q, win_peak_d;
    logic                 rst_n_rx_q, rst_n_rx_d;
    logic                 locked_q, locked_d;
    logic [3:0]           fb_shift_q, fb_shift_d;
    logic [3:0]           gd_shift_q, gd_shift_d;

    logic [15:0]          fb_abs;
    logic [15:0]          peak_new;
    logic [7:0]           smp_inc;
    logic [7:0]           good_inc;
    logic [7:0]           bad_inc;
    logic                 measuring;
    logic                 win_done;
    logic                 win_good;

    // Per-sample magnitude; the most negative code has no positive twin and saturates.
    always_comb begin
        fb_abs = feedback_tdata;
        if (feedback_tdata[15]) begin
            fb_abs = (feedback_tdata == 16'h8000) ? 16'h7FFF : (~feedback_tdata + 16'd1);
        end
        peak_new  = (fb_abs > peak_q) ? fb_abs : peak_q;
        smp_inc   = smp_cnt_q + 8'd1;
        good_inc  = good_cnt_q + 8'd1;
        bad_inc   = bad_cnt_q + 8'd1;
        measuring = (state_q == S_ACQUIRE) || (state_q == S_TRACK);
        win_done  = measuring && rx_valid && (smp_inc == WIN_LEN);
        win_good  = ({1'b0, peak_new} < THRESH);
    end

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        peak_d      = peak_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        win_peak_d  = win_peak_q;

        if (!enable) begin
            state_d     = S_IDLE;
            flush_cnt_d = '0;
            smp_cnt_d   = '0;
            peak_d      = '0;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
        end else if (relock && (state_q != S_IDLE)) begin
            // A window completing on this cycle is dropped along with its peak.
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
            smp_cnt_d   = '0;
            peak_d      = '0;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_d     = S_ACQUIRE;
                        flush_cnt_d = '0;
                        smp_cnt_d   = '0;
                        peak_d      = '0;
                        good_cnt_d  = '0;
                        bad_cnt_d   = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
                S_ACQUIRE, S_TRACK: begin
                    if (win_done) begin
                        smp_cnt_d  = '0;
                        peak_d     = '0;
                        win_peak_d = peak_new;
                        if (state_q == S_ACQUIRE) begin
                            if (!win_good) begin
                                good_cnt_d = '0;
                            end else if (good_inc == LOCK_CNT) begin
                                state_d    = S_TRACK;
                                good_cnt_d = '0;
                                bad_cnt_d  = '0;
                            end else begin
                                good_cnt_d = good_inc;
                            end
                        end else begin
                            if (win_good) begin
                                bad_cnt_d = '0;
                            end else if (bad_inc == LOSS_CNT) begin
                                state_d   = S_LOST;
                                bad_cnt_d = '0;
                            end else begin
                                bad_cnt_d = bad_inc;
                            end
                        end
                    end else if (rx_valid) begin
                        smp_cnt_d = smp_inc;
                        peak_d    = peak_new;
                    end
                end
                S_LOST: begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        rst_n_rx_d = (state_d == S_ACQUIRE) || (state_d == S_TRACK) || (state_d == S_LOST);
        locked_d   = (state_d == S_TRACK);
        fb_shift_d = locked_d ? TRK_FB : ACQ_FB;
        gd_shift_d = locked_d ? TRK_GD : ACQ_GD;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            smp_cnt_q   <= '0;
            peak_q      <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            win_peak_q  <= '0;
            rst_n_rx_q  <= 1'b0;
            locked_q    <= 1'b0;
            fb_shift_q  <= ACQ_FB;
            gd_shift_q  <= ACQ_GD;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            peak_q      <= peak_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            win_peak_q  <= win_peak_d;
            rst_n_rx_q  <= rst_n_rx_d;
            locked_q    <= locked_d;
            fb_shift_q  <= fb_shift_d;
            gd_shift_q  <= gd_shift_d;
        end
    end

    assign rst_n_rx       = rst_n_rx_q;
    assign locked         = locked_q;
    assign FEEDBACK_SHIFT = fb_shift_q;
    assign GARDNER_SHIFT  = gd_shift_q;
    assign state_dbg      = state_q;
    assign window_peak    = win_peak_q;

`ifdef RX_LOCK_STATS_EN
    logic [15:0] acq_strobes_q, acq_strobes_d;
    logic [15:0] acq_inc;
    logic [15:0] loss_events_q, loss_events_d;
    logic [15:0] lock_time_q, lock_time_d;

    // Strobes are counted only while acquiring; the count restarts whenever ACQUIRE is left.
    always_comb begin
        acq_inc       = (acq_strobes_q == 16'hFFFF) ? acq_strobes_q : (acq_strobes_q + 16'd1);
        acq_strobes_d = acq_strobes_q;
        loss_events_d = loss_events_q;
        lock_time_d   = lock_time_q;

        if (state_q != S_ACQUIRE) begin
            acq_strobes_d = '0;
        end else if (rx_valid) begin
            acq_strobes_d = acq_inc;
        end

        if ((state_q == S_ACQUIRE) && (state_d == S_TRACK)) begin
            lock_time_d = acq_inc;
        end

        if ((state_q == S_TRACK) && (state_d == S_LOST) && (loss_events_q != 16'hFFFF)) begin
            loss_events_d = loss_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (rst_32M768) begin
            acq_strobes_q <= '0;
            loss_events_q <= '0;
            lock_time_q   <= '0;
        end else begin
            acq_strobes_q <= acq_strobes_d;
            loss_events_q <= loss_events_d;
            lock_time_q   <= lock_time_d;
        end
    end

    assign loss_events = loss_events_q;
    assign lock_time   = lock_time_q;
`endif

endmodule

// File: tb/tb_rx_lock_ctrl.sv
// Self-checking bench for rx_lock_ctrl: randomized windows checked against a window-level model.
// Statistics checks are compiled in when RX_LOCK_STATS_EN is defined.
module tb_rx_lock_ctrl;

    localparam int FLUSH_CYCLES = 256;
    localparam int LOCK_WINDOW  = 64;
    localparam int LOCK_THRESH  = 128;
    localparam int LOCK_COUNT   = 4;
    localparam int LOSS_COUNT   = 2;

    logic        clk_32M768;
    logic        rst_32M768;
    logic        enable;
    logic        relock;
    logic        rx_valid;
    logic [15:0] feedback_tdata;
    logic        rst_n_rx;
    logic [3:0]  FEEDBACK_SHIFT;
    logic [3:0]  GARDNER_SHIFT;
    logic        locked;
    logic [2:0]  state_dbg;
    logic [15:0] window_peak;
`ifdef RX_LOCK_STATS_EN
    logic [15:0] loss_events;
    logic [15:0] lock_time;
`endif

    int n_compared = 0;
    int n_mismatch = 0;

    // Window-level reference model (spec encodings: 0 IDLE,1 FLUSH,2 ACQUIRE,3 TRACK,4 LOST).
    int m_state;
    int m_cnt;
    int m_peak;
    int m_wpeak;
    int m_good;
    int m_bad;
    int m_acq;
    int m_lock_time;
    int m_loss;

    rx_lock_ctrl dut (
        .clk_32M768     (clk_32M768),
        .rst_32M768     (rst_32M768),
        .enable         (enable),
        .relock         (relock),
        .rx_valid       (rx_valid),
        .feedback_tdata (feedback_tdata),
        .rst_n_rx       (rst_n_rx),
        .FEEDBACK_SHIFT (FEEDBACK_SHIFT),
        .GARDNER_SHIFT  (GARDNER_SHIFT),
        .locked         (locked),
        .state_dbg      (state_dbg),
        .window_peak    (window_peak)
`ifdef RX_LOCK_STATS_EN
        ,
        .loss_events    (loss_events),
        .lock_time      (lock_time)
`endif
    );

    initial begin
        clk_32M768 = 1'b0;
        forever #15 clk_32M768 = ~clk_32M768;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected run to end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_32M768);
        #1;
    endtask

    function automatic int abs_sat(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rand_pm(input int m);
        return int'($urandom_range(0, 2 * m)) - m;
    endfunction

    task automatic model_flush_exit();
        m_state = 2;
        m_cnt   = 0;
        m_peak  = 0;
        m_good  = 0;
        m_bad   = 0;
        m_acq   = 0;
    endtask

    task automatic model_sample(input int v);
        int  a;
        bit  good;
        if (m_state != 2 && m_state != 3) return;
        a = abs_sat(v);
        if (a > m_peak) m_peak = a;
        m_cnt++;
        if (m_state == 2) m_acq++;
        if (m_cnt == LOCK_WINDOW) begin
            m_wpeak = m_peak;
            good    = (m_peak < LOCK_THRESH);
            m_peak  = 0;
            m_cnt   = 0;
            if (m_state == 2) begin
                m_good = good ? m_good + 1 : 0;
                if (m_good == LOCK_COUNT) begin
                    m_state     = 3;
                    m_lock_time = m_acq;
                    m_bad       = 0;
                end
            end else begin
                m_bad = good ? 0 : m_bad + 1;
                if (m_bad == LOSS_COUNT) begin
                    m_state = 4;
                    m_loss++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":state"}, 32'(state_dbg), 32'(m_state));
        check({tag, ":locked"}, 32'(locked), (m_state == 3) ? 32'd1 : 32'd0);
        check({tag, ":rst_n_rx"}, 32'(rst_n_rx), (m_state >= 2) ? 32'd1 : 32'd0);
        check({tag, ":window_peak"}, 32'(window_peak), 32'(m_wpeak));
        if (m_state != 4) begin
            check({tag, ":fb_shift"}, 32'(FEEDBACK_SHIFT), (m_state == 3) ? 32'd2 : 32'd0);
            check({tag, ":gd_shift"}, 32'(GARDNER_SHIFT), (m_state == 3) ? 32'd5 : 32'd3);
        end
`ifdef RX_LOCK_STATS_EN
        check({tag, ":loss_events"}, 32'(loss_events), 32'(m_loss));
        check({tag, ":lock_time"}, 32'(lock_time), 32'(m_lock_time));
`endif
    endtask

    // One strobe after 0..2 idle cycles; outputs reflect the strobe on return.
    task automatic drive(input int v);
        repeat ($urandom_range(0, 2)) step();
        rx_valid       = 1'b1;
        feedback_tdata = 16'(v);
        step();
        rx_valid = 1'b0;
        model_sample(v);
    endtask

    task automatic window_pm(input int mag, input int n);
        for (int i = 0; i < n; i++) drive(($urandom_range(0, 1) != 0) ? mag : -mag);
    endtask

    task automatic window_with(input int special, input int rest_max);
        int pos;
        pos = int'($urandom_range(0, LOCK_WINDOW - 1));
        for (int i = 0; i < LOCK_WINDOW; i++) drive((i == pos) ? special : rand_pm(rest_max));
    endtask

    // Called while in FLUSH; counts FLUSH cycles with random strobes that must be ignored.
    task automatic wait_flush(input string tag);
        int n;
        int low;
        n   = 0;
        low = 0;
        while (state_dbg == 3'd1 && n < 1000) begin
            if (rst_n_rx == 1'b0) low++;
            rx_valid       = 1'($urandom_range(0, 1));
            feedback_tdata = 16'($urandom);
            n++;
            step();
        end
        rx_valid = 1'b0;
        check({tag, ":flush_cycles"}, 32'(n), 32'(FLUSH_CYCLES));
        check({tag, ":flush_rst_low"}, 32'(low), 32'(FLUSH_CYCLES));
        model_flush_exit();
        check_outputs({tag, ":acq_entry"});
    endtask

    task automatic lose_lock(input string tag);
        window_with(200, 127);
        window_with(-200, 127);
        check_outputs({tag, ":lost"});
        step();
        m_state = 1;
        check_outputs({tag, ":flush"});
        wait_flush(tag);
    endtask

    initial begin
        m_state     = 0;
        m_cnt       = 0;
        m_peak      = 0;
        m_wpeak     = 0;
        m_good      = 0;
        m_bad       = 0;
        m_acq       = 0;
        m_lock_time = 0;
        m_loss      = 0;

        rst_32M768     = 1'b1;
        enable         = 1'b0;
        relock         = 1'b0;
        rx_valid       = 1'b0;
        feedback_tdata = '0;
        repeat (3) step();
        check_outputs("reset");

        // Power-up flush.
        rst_32M768 = 1'b0;
        enable     = 1'b1;
        step();
        m_state = 1;
        check_outputs("start");
        wait_flush("t1");

        // Acquisition with +/-50; lock appears one cycle after the 256th strobe.
        window_pm(50, 3 * LOCK_WINDOW);
        check_outputs("t2_three_windows");
        window_pm(50, LOCK_WINDOW - 1);
        check_outputs("t2_before_last");
        window_pm(50, 1);
        check_outputs("t2_locked");

        // Isolated bad windows keep lock; two consecutive lose it.
        window_with(200, 127);
        check_outputs("t3_bad1");
        window_with(rand_pm(127), 127);
        check_outputs("t3_good");
        window_with(200, 127);
        check_outputs("t3_bad2");
        window_with(200, 127);
        check_outputs("t3_lost");
        step();
        m_state = 1;
        check_outputs("t3_flush");
        wait_flush("t3");

        // Saturation and threshold boundaries.
        window_with(-32768, 127);
        check_outputs("t4_sat");
        window_with(128, 127);
        check_outputs("t4_128");
        window_with(-127, 126);
        check_outputs("t4_127");
        for (int w = 0; w < 3; w++) begin
            window_with(rand_pm(127), 127);
            check_outputs("t4_good");
        end

        // relock together with a window completion in TRACK.
        for (int i = 0; i < LOCK_WINDOW - 1; i++) drive(rand_pm(100));
        rx_valid       = 1'b1;
        feedback_tdata = 16'd1000;
        relock         = 1'b1;
        step();
        rx_valid = 1'b0;
        relock   = 1'b0;
        m_state  = 1;
        check_outputs("t5_relock");
        wait_flush("t5");

        // enable=0 mid-ACQUIRE forces IDLE on the next edge.
        for (int i = 0; i < LOCK_WINDOW + 10; i++) drive(rand_pm(127));
        check_outputs("t5_acq");
        enable = 1'b0;
        step();
        m_state = 0;
        check_outputs("t5_idle");
        enable = 1'b1;
        step();
        m_state = 1;
        check_outputs("t5_reflush");
        wait_flush("t5b");

        // Clean acquisition then two further forced losses.
        for (int w = 0; w < LOCK_COUNT; w++) window_with(rand_pm(127), 127);
        check_outputs("t6_lock");
        lose_lock("t6_loss2");
        for (int w = 0; w < LOCK_COUNT; w++) window_with(rand_pm(127), 127);
        check_outputs("t6_relock");
        lose_lock("t6_loss3");

        // Synchronous reset mid-window drops the partial window.
        window_pm(120, 40);
        rst_32M768 = 1'b1;
        step();
        rst_32M768  = 1'b0;
        m_state     = 0;
        m_wpeak     = 0;
        m_loss      = 0;
        m_lock_time = 0;
        check_outputs("t7_reset");
        step();
        m_state = 1;
        check_outputs("t7_flush");
        wait_flush("t7");
        window_pm(30, LOCK_WINDOW);
        check_outputs("t7_window");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/rx_lock_ctrl.md
Name: rx_lock_ctrl

Overview:
- Sequences the Rx demodulator loops (carrier feedback and Gardner timing) through flush, acquisition and tracking.
- Monitors the signed carrier-loop feedback word once per Rx output sample.
- Drives wide loop shifts while acquiring and narrow shifts once locked; soft-resets the Rx core on power-up and on loss of lock.
- Sits between the top-level control registers and the Rx core, in the clk_32M768 domain.

Parameters:
- FLUSH_CYCLES, 256: clk_32M768 cycles the Rx soft reset is held.
- LOCK_WINDOW, 64: valid samples per measurement window, 2..255.
- LOCK_THRESH, 128: window peak |feedback| must be strictly below this to count as good.
- LOCK_COUNT, 4: consecutive good windows needed to declare lock.
- LOSS_COUNT, 2: consecutive bad windows in TRACK that declare loss.
- ACQ_FB_SHIFT, 0: FEEDBACK_SHIFT while acquiring.
- TRK_FB_SHIFT, 2: FEEDBACK_SHIFT while tracking.
- ACQ_GD_SHIFT, 3: GARDNER_SHIFT while acquiring.
- TRK_GD_SHIFT, 5: GARDNER_SHIFT while tracking.

Ports:
- clk_32M768, in, 1: single clock.
- rst_32M768, in, 1: synchronous, active-high reset.
- enable, in, 1: 0 forces IDLE.
- relock, in, 1: single-cycle pulse that restarts from FLUSH.
- rx_valid, in, 1: one-cycle strobe, one per Rx output sample.
- feedback_tdata, in, 16: signed carrier-loop feedback, qualified by rx_valid.
- rst_n_rx, out, 1: active-low soft reset to the Rx core.
- FEEDBACK_SHIFT, out, 4: to Rx.
- GARDNER_SHIFT, out, 4: to Rx.
- locked, out, 1: high only in TRACK.
- state_dbg, out, 3: current state encoding.
- window_peak, out, 16: unsigned peak |feedback| of the last completed window.

Behaviour:
- Reset values: state=IDLE; rst_n_rx=0; FEEDBACK_SHIFT=ACQ_FB_SHIFT; GARDNER_SHIFT=ACQ_GD_SHIFT; locked=0; window_peak=0; all counters 0. All outputs are registered.
- State encodings: IDLE=0, FLUSH=1, ACQUIRE=2, TRACK=3, LOST=4.
- IDLE:
  - rst_n_rx=0.
  - enable=1 moves to FLUSH on the next cycle.
- FLUSH:
  - rst_n_rx=0; shifts set to the ACQ values; flush counter counts up from 0.
  - After FLUSH_CYCLES cycles in FLUSH, go to ACQUIRE with rst_n_rx=1 and window/good counters cleared.
- Window measurement (ACQUIRE, TRACK):
  - On each rx_valid, compute |feedback_tdata|; -32768 saturates to 32767.
  - Update running peak = max(peak, abs).
  - Sample counter increments per rx_valid.
  - When the counter reaches LOCK_WINDOW (counting the current sample): latch the final peak into window_peak, classify good = peak < LOCK_THRESH, restart peak at 0 and counter at 0 in the same cycle.
  - rx_valid samples outside ACQUIRE/TRACK are ignored.
- ACQUIRE:
  - Good window: good_cnt++. Bad window: good_cnt=0.
  - good_cnt reaching LOCK_COUNT moves to TRACK.
  - The shift outputs switch to the TRK values on the same clock edge as entry to TRACK; locked=1 from that edge.
- TRACK:
  - Bad window: bad_cnt++. Good window: bad_cnt=0.
  - bad_cnt reaching LOSS_COUNT moves to LOST; locked=0 on the same edge.
- LOST:
  - One cycle only; restore the ACQ shifts, then go to FLUSH.
  - FLUSH re-asserts the soft reset.
- Event priority, highest first: rst_32M768, then enable=0 (to IDLE from any state, immediately), then relock (to FLUSH from any non-IDLE state, counters cleared), then window evaluation.
- relock in IDLE is ignored.
- A window completing in the same cycle as relock is discarded; window_peak is not updated.
- Synchronous reset mid-window discards the partial window.
- Latency: from the final rx_valid of the LOCK_COUNT-th good window, locked rises 1 cycle later.

Optional Feature:
- Macro: RX_LOCK_STATS_EN.
- When defined:
  - Extra outputs loss_events (16-bit) and lock_time (16-bit).
  - loss_events increments on each TRACK->LOST transition and saturates at 0xFFFF.
  - lock_time counts rx_valid strobes from FLUSH exit to TRACK entry. It is latched at TRACK entry and saturating.
  - Both clear only on rst_32M768.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset released, enable=1 at cycle 0 -> rst_n_rx low for exactly 256 cycles in FLUSH, then high; state_dbg=2, FEEDBACK_SHIFT=0, GARDNER_SHIFT=3.
2. ACQUIRE with feedback=±50 for 256 rx_valid -> locked=1 one cycle after the 256th strobe; FEEDBACK_SHIFT=2, GARDNER_SHIFT=5; window_peak=50.
3. In TRACK, one window with a single sample of 200, then a good window, then a further single-200 window -> stays locked (bad_cnt resets); two consecutive windows each containing 200 -> LOST for 1 cycle, then FLUSH with rst_n_rx=0 and shifts 0/3.
4. feedback=-32768 in a window -> window_peak=32767, classified bad; 127 good, 128 bad (threshold boundary).
5. relock pulse coincident with a window completion in TRACK -> FLUSH next cycle, window_peak unchanged; enable=0 in the middle of ACQUIRE -> IDLE next cycle, rst_n_rx=0.
6. With RX_LOCK_STATS_EN, three forced loss events -> loss_events=3; lock_time=256 after a clean acquisition.
